// File: rtl/product_display_pkg.sv
// product_display_pkg: shared FSM encoding, widths and seven-segment patterns
// for the product display block.
package product_display_pkg;
    localparam int BCD_W = 20;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Active-low g..a patterns; entry 0 is the rightmost slice.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : SEG_TABLE[d];
    endfunction
endpackage

// File: rtl/product_display_if.sv
// product_display_if: load/product request and display outputs of the product display.
interface product_display_if;
    logic [15:0] product;
    logic        load;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    modport master(output product, load, input busy, an, seg, dp);
    modport slave(input product, load, output busy, an, seg, dp);
endinterface

// File: rtl/product_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one input bit per clock; a load
// at any time restarts the conversion from the newly captured value.
module bin2bcd_seq
    import product_display_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [15:0]      i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    state_t           r_state;
    logic [15:0]      r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_bitcnt;
    logic [BCD_W-1:0] w_adj;

    for (genvar g = 0; g < BCD_W / 4; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3 : r_bcd[4*g +: 4];
    end

    assign o_bcd = r_bcd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else if (i_load) begin
            r_state  <= CONV;
            r_bin    <= i_bin;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
        end else begin
            case (r_state)
                CONV: begin
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_bitcnt       <= r_bitcnt + 4'd1;
                    r_state        <= (r_bitcnt == 4'd15) ? DONE : CONV;
                    o_done         <= (r_bitcnt == 4'd15);
                end
                DONE: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/product_display.sv
// product_display: converts the multiplier product to BCD and scans it onto a
// 4-digit active-low seven-segment display with leading-zero blanking.
module product_display
    import product_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input logic                i_clock,
    input logic                i_reset,
    product_display_if.slave   bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [BCD_W-1:0] w_bcd, w_dig_n, r_dig;
    logic             w_done, w_wrap, w_blank;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_idx, w_idx_n;
    logic [3:0]       w_nib, w_lz, r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    bin2bcd_seq u_conv (
        .i_clk  (i_clock),
        .i_rst  (i_reset),
        .i_load (bus.load),
        .i_bin  (bus.product),
        .o_busy (bus.busy),
        .o_done (w_done),
        .o_bcd  (w_bcd)
    );

    // Output registers are fed from next-state digits and index so an, seg
    // and dp track the architectural state with no extra cycle of lag.
    assign w_wrap  = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_idx_n = r_idx + {1'b0, w_wrap};
    assign w_dig_n = (w_done && !bus.load) ? w_bcd : r_dig;
    assign w_nib   = w_dig_n[{w_idx_n, 2'b00} +: 4];
    assign w_lz[3] = (w_dig_n[19:16] == 4'd0) && (w_dig_n[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] && (w_dig_n[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] && (w_dig_n[7:4] == 4'd0);
    assign w_lz[0] = 1'b0;
    assign w_blank = (BLANK_LZ != 0) && w_lz[w_idx_n];

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_dig <= '0;
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_idx <= w_idx_n;
            r_dig <= w_dig_n;
            r_an  <= ~(4'b0001 << w_idx_n);
            r_seg <= w_blank ? SEG_BLANK : seg_of(w_nib);
            r_dp  <= !((w_idx_n == 2'd3) && (w_dig_n[19:16] != 4'd0));
        end
    end
endmodule

// File: tb/tb_product_display.sv
// tb_product_display: random and directed loads checked every cycle against a
// decimal-arithmetic display model, plus literal segment checks.
module tb_product_display;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    product_display_if bus();
    product_display_if bus0();
    assign bus0.product = bus.product;
    assign bus0.load    = bus.load;

    product_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));
    product_display #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut0 (.i_clock(clk), .i_reset(rst), .bus(bus0));

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int p10 [5] = '{1, 10, 100, 1000, 10000};

    // Model: k = clock edges since reset, cd = edges left until the pending value is shown.
    int k, cd, val, pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; cd = 0; val = 0; pend = 0;
        end else begin
            k++;
            if (bus.load) begin
                pend = int'(bus.product);
                cd = 17;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) val = pend;
            end
        end
    end

    function automatic int idx_of(int kk);
        return (kk / DIV) % 4;
    endfunction
    function automatic logic [3:0] exp_an(int kk);
        return (kk == 0) ? 4'hF : ~(4'b0001 << idx_of(kk));
    endfunction
    function automatic logic [6:0] exp_seg(int kk, int v, bit blz);
        int i;
        i = idx_of(kk);
        if (kk == 0) return 7'h7F;
        if (blz && i > 0 && v < p10[i]) return 7'h7F;
        return segs[(v / p10[i]) % 10];
    endfunction
    function automatic logic exp_dp(int kk, int v);
        return (kk == 0) ? 1'b1 : !(idx_of(kk) == 3 && v >= 10000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(cd > 0));
        check("an", 32'(bus.an), 32'(exp_an(k)));
        check("seg", 32'(bus.seg), 32'(exp_seg(k, val, 1'b1)));
        check("dp", 32'(bus.dp), 32'(exp_dp(k, val)));
        check("busy0", 32'(bus0.busy), 32'(cd > 0));
        check("an0", 32'(bus0.an), 32'(exp_an(k)));
        check("seg0", 32'(bus0.seg), 32'(exp_seg(k, val, 1'b0)));
        check("dp0", 32'(bus0.dp), 32'(exp_dp(k, val)));
    end

    task automatic ld(input logic [15:0] v);
        @(posedge clk);
        #1 bus.product = v;
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.an !== target && n < 4 * DIV + 2) begin
            @(negedge clk);
            n++;
        end
        check("wait_an", 32'(bus.an), 32'(target));
    endtask

    task automatic pin(input logic [3:0] a, input logic [6:0] s, input logic d);
        wait_an(a);
        #1;
        check("pin_seg", 32'(bus.seg), 32'(s));
        check("pin_dp", 32'(bus.dp), 32'(d));
    endtask

    initial begin
        bus.product = '0;
        bus.load = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // Idle after reset: only units shows 0; unblanked DUT shows 0 everywhere.
        repeat (20) @(posedge clk);
        pin(4'b1110, 7'h40, 1'b1);
        pin(4'b0111, 7'h7F, 1'b1);
        check("noblank_seg", 32'(bus0.seg), 32'h40);

        ld(16'd65025);
        repeat (17) @(posedge clk);
        pin(4'b0111, 7'h12, 1'b0);
        pin(4'b1110, 7'h12, 1'b1);
        pin(4'b1101, 7'h24, 1'b1);
        pin(4'b1011, 7'h40, 1'b1);

        ld(16'd255);
        repeat (17) @(posedge clk);
        pin(4'b1110, 7'h12, 1'b1);
        pin(4'b1101, 7'h12, 1'b1);
        pin(4'b1011, 7'h24, 1'b1);
        pin(4'b0111, 7'h7F, 1'b1);

        ld(16'd1234);
        repeat (4) @(posedge clk);
        ld(16'd9999);
        repeat (17) @(posedge clk);
        pin(4'b0111, 7'h10, 1'b1);

        // Short asynchronous reset between edges in the middle of a conversion.
        ld(16'd500);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        #2 rst = 1'b0;
        ld(16'd7);
        repeat (17) @(posedge clk);
        pin(4'b1110, 7'h78, 1'b1);
        pin(4'b1101, 7'h7F, 1'b1);

        ld(16'd10000);
        repeat (17) @(posedge clk);
        pin(4'b0111, 7'h40, 1'b0);
        pin(4'b1110, 7'h40, 1'b1);

        foreach (p10[i]) begin
            ld(16'(p10[i] - 1));
            repeat (20) @(posedge clk);
            ld(16'(p10[i]));
            repeat (20) @(posedge clk);
        end
        ld(16'd65535);
        repeat (24) @(posedge clk);

        for (int i = 0; i < 60; i++) begin
            ld(16'($urandom_range(0, 65535)));
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        repeat (30) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
